k2_sequencer: RTL and testbench

Multi-cycle control sequencer for the K2 8-bit datapath: program counter, instruction ROM, registers A/B/OUT, add/sub ALU and carry flag. It latches each instruction word and decodes it. It then drives register enables, mux select and ALU op, owns the carry flag, and commands PC increment or jump. Run, halt and single-step controls let a debug host or testbench start, stop and walk programs.

---
 rtl/k2_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_k2_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k2_sequencer.sv
// K2 control sequencer: fetch/exec/update FSM with run, halt and single-step control.
// Latches each instruction word, decodes it into register enables and PC commands,
// and owns the architectural carry flag and the retired-instruction counter.
module k2_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       instr_i,
    input  logic [7:0]       pc_i,
    input  logic             carry_i,
    input  logic             run_i,
    input  logic             halt_req_i,
    input  logic             step_req_i,
    output logic             step_ack_o,
    output logic             en_a_o,
    output logic             en_b_o,
    output logic             en_out_o,
    output logic             mux_sel_o,
    output logic             alu_sub_o,
    output logic             pc_inc_o,
    output logic             pc_load_o,
    output logic [2:0]       pc_target_o,
    output logic             carry_flag_o,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    localparam int unsigned IR_W  = 8;
    localparam int unsigned IMM_W = 3;

    localparam logic [1:0] DST_A   = 2'b11;
    localparam logic [1:0] DST_B   = 2'b10;
    localparam logic [1:0] DST_OUT = 2'b01;

    typedef enum logic [1:0] {
        ST_HALT   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC   = 2'b10,
        ST_UPDATE = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_mode_q, step_mode_d;
    logic               ack_q, ack_d;
    logic               run_block_q, run_block_d;

    // Instruction fields, always taken from the latched word.
    logic               ir_j;
    logic               ir_c;
    logic [1:0]         ir_dst;
    logic               ir_sreg;
    logic [IMM_W-1:0]   ir_imm;

    assign ir_j    = ir_q[7];
    assign ir_c    = ir_q[6];
    assign ir_dst  = ir_q[5:4];
    assign ir_sreg = ir_q[3];
    assign ir_imm  = ir_q[2:0];

    logic run_ok;
    logic self_loop;
    logic take;

    assign run_ok    = run_i && !halt_req_i && !run_block_q;
    assign self_loop = ir_j && (8'({5'b0, ir_imm}) == pc_i);
    assign take      = ir_j | (ir_c & carry_q);

    // State and architectural registers; synchronous reset discards any partial instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALT;
            ir_q        <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            step_mode_q <= 1'b0;
            ack_q       <= 1'b0;
            run_block_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            step_mode_q <= step_mode_d;
            ack_q       <= ack_d;
            run_block_q <= run_block_d;
        end
    end

    // Next-state logic: sequencing, carry capture, retirement, step handshake, self-loop lockout.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        step_mode_d = step_mode_q;
        ack_d       = ack_q;
        run_block_d = run_block_q;

        // A run lockout clears once run_i has been seen low; ack drops once the request is gone.
        if (!run_i) begin
            run_block_d = 1'b0;
        end
        if (!step_req_i) begin
            ack_d = 1'b0;
        end

        unique case (state_q)
            ST_HALT: begin
                // Step wins over a simultaneous run request.
                if (step_req_i && !ack_q) begin
                    state_d     = ST_FETCH;
                    step_mode_d = 1'b1;
                end else if (run_ok) begin
                    state_d     = ST_FETCH;
                    step_mode_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ir_d    = instr_i;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // ALU writes to A or B update the flag; immediate loads and OUT do not.
                if (!ir_sreg && ir_dst[1]) begin
                    carry_d = carry_i;
                end
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (self_loop) begin
                    run_block_d = 1'b1;
                end
                if (!step_mode_q && run_ok && !self_loop) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                    if (step_mode_q) begin
                        ack_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Output decode from registered state and IR; reset suppresses any strobe in its cycle.
    always_comb begin
        en_a_o    = 1'b0;
        en_b_o    = 1'b0;
        en_out_o  = 1'b0;
        pc_inc_o  = 1'b0;
        pc_load_o = 1'b0;

        if (!reset && state_q == ST_EXEC) begin
            en_a_o   = (ir_dst == DST_A);
            en_b_o   = (ir_dst == DST_B);
            en_out_o = (ir_dst == DST_OUT);
        end
        if (!reset && state_q == ST_UPDATE) begin
            pc_load_o = take;
            pc_inc_o  = !take;
        end

        mux_sel_o     = ir_sreg;
        alu_sub_o     = ir_imm[2];
        pc_target_o   = ir_imm;
        carry_flag_o  = carry_q;
        halted_o      = (state_q == ST_HALT);
        state_o       = state_q;
        step_ack_o    = ack_q;
        instr_count_o = cnt_q;
    end

endmodule

// File: tb/tb_k2_sequencer.sv
// Self-checking bench for k2_sequencer: directed scenarios plus randomized control traffic
// compared every cycle against an instruction-level reference model.
module tb_k2_sequencer;

    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    instr_i;
    logic [7:0]    pc_i;
    logic          carry_i;
    logic          run_i;
    logic          halt_req_i;
    logic          step_req_i;
    logic          step_ack_o;
    logic          en_a_o, en_b_o, en_out_o;
    logic          mux_sel_o, alu_sub_o;
    logic          pc_inc_o, pc_load_o;
    logic [2:0]    pc_target_o;
    logic          carry_flag_o;
    logic          halted_o;
    logic [1:0]    state_o;
    logic [CW-1:0] instr_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    k2_sequencer #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .carry_i       (carry_i),
        .run_i         (run_i),
        .halt_req_i    (halt_req_i),
        .step_req_i    (step_req_i),
        .step_ack_o    (step_ack_o),
        .en_a_o        (en_a_o),
        .en_b_o        (en_b_o),
        .en_out_o      (en_out_o),
        .mux_sel_o     (mux_sel_o),
        .alu_sub_o     (alu_sub_o),
        .pc_inc_o      (pc_inc_o),
        .pc_load_o     (pc_load_o),
        .pc_target_o   (pc_target_o),
        .carry_flag_o  (carry_flag_o),
        .halted_o      (halted_o),
        .state_o       (state_o),
        .instr_count_o (instr_count_o)
    );

    // Tiny program memory and PC driven by the DUT's own strobes.
    logic [7:0] rom [8];
    logic [7:0] pc_q = 8'd0;

    always @(posedge clk) begin
        if (reset)          pc_q <= 8'd0;
        else if (pc_load_o) pc_q <= {5'b0, pc_target_o};
        else if (pc_inc_o)  pc_q <= pc_q + 8'd1;
    end

    assign instr_i = rom[pc_q[2:0]];
    assign pc_i    = pc_q;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: an instruction is either idle or in its 1st/2nd/3rd cycle.
    bit         m_busy  = 1'b0;
    int         m_cyc   = 0;
    bit         m_step  = 1'b0;
    bit         m_ack   = 1'b0;
    bit         m_block = 1'b0;
    bit         m_flag  = 1'b0;
    logic [7:0] m_ir    = 8'd0;
    int         m_cnt   = 0;
    bit         m_hit   = 1'b0;
    bit         chk_on  = 1'b0;

    always @(posedge clk) begin
        chk_on = 1'b1;
        if (reset) begin
            m_busy = 0; m_cyc = 0; m_step = 0; m_ack = 0;
            m_block = 0; m_flag = 0; m_ir = 8'd0; m_cnt = 0;
        end else begin
            if (!run_i)      m_block = 0;
            if (!step_req_i) m_ack   = 0;
            if (!m_busy) begin
                if (step_req_i && !m_ack) begin
                    m_busy = 1; m_cyc = 0; m_step = 1;
                end else if (run_i && !halt_req_i && !m_block) begin
                    m_busy = 1; m_cyc = 0; m_step = 0;
                end
            end else if (m_cyc == 0) begin
                m_ir  = instr_i;
                m_cyc = 1;
            end else if (m_cyc == 1) begin
                if (!m_ir[3] && m_ir[5]) m_flag = carry_i;
                m_cyc = 2;
            end else begin
                m_hit = m_ir[7] && (int'(pc_i) == int'(m_ir[2:0]));
                if (m_cnt < MAXC) m_cnt = m_cnt + 1;
                if (m_hit) m_block = 1;
                if (!m_step && run_i && !halt_req_i && !m_hit) begin
                    m_cyc = 0;
                end else begin
                    m_busy = 0;
                    if (m_step) m_ack = 1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            bit live, exec, upd, take;
            live = !reset;
            exec = live && m_busy && m_cyc == 1;
            upd  = live && m_busy && m_cyc == 2;
            take = m_ir[7] | (m_ir[6] & m_flag);
            chk("m_state",   32'(state_o),       m_busy ? m_cyc + 1 : 0);
            chk("m_halted",  32'(halted_o),      m_busy ? 0 : 1);
            chk("m_en_a",    32'(en_a_o),        int'(exec && m_ir[5:4] == 2'b11));
            chk("m_en_b",    32'(en_b_o),        int'(exec && m_ir[5:4] == 2'b10));
            chk("m_en_out",  32'(en_out_o),      int'(exec && m_ir[5:4] == 2'b01));
            chk("m_mux_sel", 32'(mux_sel_o),     int'(m_ir[3]));
            chk("m_alu_sub", 32'(alu_sub_o),     int'(m_ir[2]));
            chk("m_pc_load", 32'(pc_load_o),     int'(upd && take));
            chk("m_pc_inc",  32'(pc_inc_o),      int'(upd && !take));
            chk("m_target",  32'(pc_target_o),   int'(m_ir[2:0]));
            chk("m_flag",    32'(carry_flag_o),  int'(m_flag));
            chk("m_count",   32'(instr_count_o), m_cnt);
            chk("m_ack",     32'(step_ack_o),    int'(m_ack));
        end
    end

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic carry_branch(input logic cval);
        reset_pulse();
        rom[0]  = 8'h30;
        rom[1]  = 8'h45;
        carry_i = cval;
        run_i   = 1'b1;
        tick(6);
        chk("br_flag",   32'(carry_flag_o), int'(cval));
        chk("br_load",   32'(pc_load_o),    int'(cval));
        chk("br_inc",    32'(pc_inc_o),     int'(!cval));
        chk("br_target", 32'(pc_target_o),  5);
        run_i = 1'b0;
        tick(2);
    endtask

    initial begin
        reset = 1'b1; run_i = 1'b0; halt_req_i = 1'b0; step_req_i = 1'b0; carry_i = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        tick(2);
        reset = 1'b0;

        // Idle after reset.
        tick(10);
        chk("idle_state",   32'(state_o),       0);
        chk("idle_halted",  32'(halted_o),      1);
        chk("idle_count",   32'(instr_count_o), 0);
        chk("idle_strobes", 32'({en_a_o, en_b_o, en_out_o, pc_inc_o, pc_load_o, step_ack_o}), 0);

        // B<=imm3 (encoded 0x2B), A<=imm5, A<=A+B.
        rom[0] = 8'h2B; rom[1] = 8'h3D; rom[2] = 8'h30;
        run_i = 1'b1;
        tick();
        chk("p1_fetch", 32'(state_o), 1);
        tick();
        chk("p1_en_b_c2", 32'(en_b_o),    1);
        chk("p1_mux_c2",  32'(mux_sel_o), 1);
        tick();
        chk("p1_inc_c3", 32'(pc_inc_o), 1);
        tick(2);
        chk("p1_en_a_c5", 32'(en_a_o),    1);
        chk("p1_mux_c5",  32'(mux_sel_o), 1);
        tick(3);
        chk("p1_en_a_c8", 32'(en_a_o),    1);
        chk("p1_mux_c8",  32'(mux_sel_o), 0);
        tick();
        run_i = 1'b0;
        tick();
        chk("p1_count", 32'(instr_count_o), 3);
        chk("p1_halt",  32'(halted_o),      1);

        // Conditional branch on carry, taken then not taken.
        carry_branch(1'b1);
        carry_branch(1'b0);

        // Single step with a held request.
        reset_pulse();
        rom[0] = 8'h2B;
        step_req_i = 1'b1;
        tick();
        chk("st_fetch", 32'(state_o), 1);
        tick(3);
        chk("st_halt",  32'(state_o),       0);
        chk("st_ack",   32'(step_ack_o),    1);
        chk("st_count", 32'(instr_count_o), 1);
        tick(5);
        chk("st_hold_state", 32'(state_o),       0);
        chk("st_hold_count", 32'(instr_count_o), 1);
        chk("st_hold_ack",   32'(step_ack_o),    1);
        step_req_i = 1'b0;
        chk("st_ack_drop_same", 32'(step_ack_o), 1);
        tick();
        chk("st_ack_low", 32'(step_ack_o), 0);
        step_req_i = 1'b1;
        tick();
        chk("st2_fetch", 32'(state_o), 1);
        tick(3);
        chk("st2_count", 32'(instr_count_o), 2);
        step_req_i = 1'b0;
        tick(2);

        // Self-loop jump halts despite run_i; needs a run_i toggle to restart.
        reset_pulse();
        rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h82;
        run_i = 1'b1;
        tick(9);
        chk("sl_load",   32'(pc_load_o),   1);
        chk("sl_target", 32'(pc_target_o), 2);
        tick();
        chk("sl_halt", 32'(halted_o), 1);
        tick(5);
        chk("sl_stay", 32'(halted_o), 1);
        run_i = 1'b0;
        tick();
        run_i = 1'b1;
        tick();
        chk("sl_restart", 32'(state_o), 1);
        run_i = 1'b0;
        tick(4);

        // halt_req during EXEC completes the instruction first.
        reset_pulse();
        rom[0] = 8'h2B; rom[1] = 8'h00;
        run_i = 1'b1;
        tick(2);
        halt_req_i = 1'b1;
        tick();
        chk("hr_update", 32'(state_o),  3);
        chk("hr_inc",    32'(pc_inc_o), 1);
        tick();
        chk("hr_halt", 32'(state_o), 0);
        halt_req_i = 1'b0;
        run_i = 1'b0;
        tick();

        // Reset during EXEC suppresses the enable and returns to HALT.
        reset_pulse();
        run_i = 1'b1;
        tick(2);
        reset = 1'b1;
        #1;
        chk("rx_en_b", 32'(en_b_o), 0);
        tick();
        chk("rx_state", 32'(state_o),       0);
        chk("rx_count", 32'(instr_count_o), 0);
        reset = 1'b0;
        run_i = 1'b0;
        tick();

        // Retired counter saturates.
        reset_pulse();
        for (int i = 0; i < 8; i++) rom[i] = 8'h00;
        run_i = 1'b1;
        tick(60);
        run_i = 1'b0;
        tick(4);
        chk("sat_count", 32'(instr_count_o), MAXC);

        // Randomized programs and control traffic.
        for (int ep = 0; ep < 16; ep++) begin
            for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
            reset_pulse();
            for (int cyc = 0; cyc < 220; cyc++) begin
                carry_i = 1'($urandom);
                if (ep % 2 == 0) run_i = ($urandom_range(0, 15) != 0);
                else             run_i = ($urandom_range(0, 7) == 0);
                halt_req_i = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 3) == 0) step_req_i = ~step_req_i;
                reset = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        reset = 1'b0; run_i = 1'b0; halt_req_i = 1'b0; step_req_i = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
